// File: rtl/gyro_rx_packetizer_if.sv
// ---------------------------------------------------------------------------
// gyro_rx_packetizer_if
// Stream signals between the gyro receive FIFO, the packetizer and the
// DMA/AXI-Stream sink.
//
// Handshake: a word moves on a rising clock edge exactly when its valid and
// ready are both high at that edge. A producer holding valid high must keep
// its data (and last) stable until the word moves; ready may change freely.
//
//   in_data   [15:0]  FIFO sample               (FIFO -> packetizer)
//   in_valid          sample available          (FIFO -> packetizer)
//   in_ready          packetizer takes sample   (packetizer -> FIFO)
//   out_data  [15:0]  packet word               (packetizer -> sink)
//   out_valid         out_data valid            (packetizer -> sink)
//   out_last          final word of packet      (packetizer -> sink)
//   out_ready         sink takes word           (sink -> packetizer)
//
// slave  : the packetizer's view.
// master : the view of the environment around it (FIFO + sink).
// ---------------------------------------------------------------------------
interface gyro_rx_packetizer_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/gyro_rx_packetizer.sv
// ---------------------------------------------------------------------------
// gyro_rx_packetizer
// Frames the 16-bit gyro sample stream into packets: one header word
// {HDR_TAG, seq[11:0]} followed by N = 64 << packet_sel samples, with
// out_last on the final sample. Keeps a 12-bit packet sequence number and a
// 32-bit completed-packet counter.
//
// Ports:
//   clock          block clock (serializer txclk domain)
//   reset_n        asynchronous active-low reset
//   enable         run request, sampled only at packet boundaries
//   debug_clear    synchronous clear of seq and packet_count
//   packet_sel[2:0] packet length select, N = 64 << packet_sel
//   busy           registered, high while the FSM is not IDLE
//   packet_count   completed packets, wraps at 2^32
//   state_dbg[1:0] current FSM state (0 IDLE, 1 HEADER, 2 DATA)
//   bus            stream interface (slave modport)
// ---------------------------------------------------------------------------
module gyro_rx_packetizer #(
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  debug_clear,
  input  logic [2:0]            packet_sel,
  output logic                  busy,
  output logic [31:0]           packet_count,
  output logic [1:0]            state_dbg,
  gyro_rx_packetizer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] len_q;
  logic [13:0] sample_cnt_q;
  logic [11:0] seq;
  logic [15:0] out_data_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic        busy_q;

  logic        adv;
  logic        in_ready_w;
  logic        accept;
  logic        at_last;
  logic        last_sample;
  logic        hdr_load;
  logic        len_load;
  logic [13:0] sel_len;

  // 64 << 7 = 8192 still fits in 14 bits.
  assign sel_len = 14'd64 << packet_sel;

  // The output register can take a new word when it is empty or being drained.
  assign adv         = ~out_valid_q | bus.out_ready;
  // Only registered state and out_ready feed in_ready; in_valid never does.
  assign in_ready_w  = (state_q == S_DATA) & adv;
  assign accept      = bus.in_valid & in_ready_w;
  assign at_last     = (sample_cnt_q == (len_q - 14'd1));
  assign last_sample = accept & at_last;

  always_comb begin
    state_d  = state_q;
    len_load = 1'b0;
    hdr_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_HEADER;
          len_load = 1'b1;
        end
      end
      S_HEADER: begin
        if (adv) begin
          state_d  = S_DATA;
          hdr_load = 1'b1;
        end
      end
      S_DATA: begin
        // enable and packet_sel only matter here, at the packet boundary.
        if (last_sample) begin
          if (enable) begin
            state_d  = S_HEADER;
            len_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q        <= 14'd64;
      sample_cnt_q <= 14'd0;
    end else begin
      if (len_load) len_q <= sel_len;
      if (hdr_load) begin
        sample_cnt_q <= 14'd0;
      end else if (accept) begin
        sample_cnt_q <= sample_cnt_q + 14'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= 16'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (hdr_load) begin
        out_data_q  <= {HDR_TAG, seq};
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
      end else if (accept) begin
        out_data_q  <= bus.in_data;
        out_valid_q <= 1'b1;
        out_last_q  <= at_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // debug_clear wins over a coincident end-of-packet increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq          <= 12'd0;
      packet_count <= 32'd0;
    end else if (debug_clear) begin
      seq          <= 12'd0;
      packet_count <= 32'd0;
    end else if (last_sample) begin
      seq          <= seq + 12'd1;
      packet_count <= packet_count + 32'd1;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_gyro_rx_packetizer.sv
// ---------------------------------------------------------------------------
// tb_gyro_rx_packetizer
// Directed bench for gyro_rx_packetizer. Expected packet words (header and
// samples with their last flag) are queued in exp_q by the bench and popped
// by a monitor as words leave the DUT. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_gyro_rx_packetizer;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        debug_clear;
  logic [2:0]  packet_sel;
  logic        busy;
  logic [31:0] packet_count;
  logic [1:0]  state_dbg;
  logic        rdy_rand;

  gyro_rx_packetizer_if bus ();

  gyro_rx_packetizer #(.HDR_TAG(4'hA)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .debug_clear  (debug_clear),
    .packet_sel   (packet_sel),
    .busy         (busy),
    .packet_count (packet_count),
    .state_dbg    (state_dbg),
    .bus          (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [16:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- sink ready driver ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  initial begin : monitor
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    logic [16:0] e;
    prev_stall = 1'b0;
    prev_data  = 16'd0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", bus.out_data, prev_data);
          check("hold_last", bus.out_last, prev_last);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            check("word_data", bus.out_data, e[15:0]);
            check("word_last", bus.out_last, e[16]);
          end
        end
        prev_stall = bus.out_valid & ~bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_pkt(input logic [15:0] hdr, input int n, input logic [15:0] base);
    exp_q.push_back({1'b0, hdr});
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 16'(i)});
  endtask

  // act: 0 none, 1 drop enable at act_at, 2 drop enable and set packet_sel=2
  // at act_at, 3 raise debug_clear with the final acceptance, 4 stop after
  // act_at samples. Returns 1 ns after a rising edge with in_valid low.
  task automatic drive_pkt(input int n, input logic [15:0] base, input int gap_pct,
                           input int act_at, input int act);
    int sent = 0;
    int cyc  = 0;
    bit stopped = 0;
    while (sent < n && cyc < 20000) begin
      @(posedge clock);
      #1;
      debug_clear = 1'b0;
      if (act == 4 && sent == act_at) begin
        stopped = 1;
        break;
      end
      if (act == 1 && sent == act_at) enable = 1'b0;
      if (act == 2 && sent == act_at) begin
        enable     = 1'b0;
        packet_sel = 3'd2;
      end
      bus.in_valid = ($urandom_range(1, 100) > gap_pct);
      bus.in_data  = base + 16'(sent);
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) begin
        if (act == 3 && sent == n - 1) debug_clear = 1'b1;
        sent++;
      end
      cyc++;
    end
    if (!stopped) begin
      @(posedge clock);
      #1;
      check("drive_done", sent, n);
    end
    bus.in_valid = 1'b0;
    debug_clear  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      @(negedge clock);
      c++;
    end
    check(tag, 32'(exp_q.size()), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy !== 1'b0 && c < 100) begin
      @(negedge clock);
      c++;
    end
    check(tag, busy, 0);
    check({tag, "_state"}, state_dbg, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_packet_count", packet_count, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    debug_clear  = 1'b0;
    packet_sel   = 3'd0;
    rdy_rand     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Basic packets and start-up timing: headers 0xA000, 0xA001.
    expect_pkt(16'hA000, 64, 16'h0000);
    expect_pkt(16'hA001, 64, 16'h0100);
    @(posedge clock);
    #1;
    enable = 1'b1;
    @(negedge clock);
    check("idle_busy", busy, 0);
    @(negedge clock);
    check("start_busy", busy, 1);
    check("start_state", state_dbg, 1);
    check("hdr_in_ready", bus.in_ready, 0);
    check("start_valid", bus.out_valid, 0);
    @(negedge clock);
    check("hdr_valid", bus.out_valid, 1);
    check("hdr_data", bus.out_data, 32'h0000_A000);
    drive_pkt(64, 16'h0000, 0, 0, 0);
    check("count_pkt1", packet_count, 1);
    drive_pkt(64, 16'h0100, 0, 10, 1);
    drain("drain_basic");
    wait_idle("idle_basic");
    check("count_basic", packet_count, 2);

    // Backpressure: 128-sample packets, random sink stalls and input gaps.
    packet_sel = 3'd1;
    rdy_rand   = 1'b1;
    expect_pkt(16'hA002, 128, 16'h1000);
    expect_pkt(16'hA003, 128, 16'h2000);
    enable = 1'b1;
    drive_pkt(128, 16'h1000, 30, 0, 0);
    drive_pkt(128, 16'h2000, 30, 50, 1);
    drain("drain_bp");
    rdy_rand = 1'b0;
    wait_idle("idle_bp");
    check("count_bp", packet_count, 4);

    // Mid-packet change: sel -> 2 and enable drop at sample 30 of a 64 packet.
    packet_sel = 3'd0;
    expect_pkt(16'hA004, 64, 16'h3000);
    enable = 1'b1;
    drive_pkt(64, 16'h3000, 0, 30, 2);
    drain("drain_mid");
    wait_idle("idle_mid");
    repeat (10) @(posedge clock);
    #1;
    check("mid_no_header", bus.out_valid, 0);
    check("count_mid", packet_count, 5);
    expect_pkt(16'hA005, 256, 16'h4000);
    enable = 1'b1;
    drive_pkt(256, 16'h4000, 0, 100, 1);
    drain("drain_256");
    wait_idle("idle_256");

    // Maximum length: 8192 samples, last on index 8191.
    packet_sel = 3'd7;
    expect_pkt(16'hA006, 8192, 16'h8000);
    enable = 1'b1;
    drive_pkt(8192, 16'h8000, 0, 5, 1);
    drain("drain_max");
    wait_idle("idle_max");
    check("count_max", packet_count, 7);

    // Sequence wrap: preload seq to 4095 while idle, header after 0xAFFF is 0xA000.
    force dut.seq = 12'hFFF;
    @(posedge clock);
    #1;
    release dut.seq;
    packet_sel = 3'd0;
    expect_pkt(16'hAFFF, 64, 16'hA000);
    expect_pkt(16'hA000, 64, 16'hB000);
    enable = 1'b1;
    drive_pkt(64, 16'hA000, 0, 0, 0);
    drive_pkt(64, 16'hB000, 0, 5, 1);
    drain("drain_wrap");
    wait_idle("idle_wrap");
    check("count_wrap", packet_count, 9);

    // debug_clear coinciding with the final sample acceptance.
    expect_pkt(16'hA001, 64, 16'hC000);
    expect_pkt(16'hA000, 64, 16'hD000);
    enable = 1'b1;
    drive_pkt(64, 16'hC000, 0, 0, 3);
    check("count_clr", packet_count, 0);
    drive_pkt(64, 16'hD000, 0, 5, 1);
    drain("drain_clr");
    wait_idle("idle_clr");
    check("count_after_clr", packet_count, 1);

    // Reset at sample 20: no last emitted, next header carries seq 0.
    expect_pkt(16'hA001, 19, 16'hE000);
    void'(exp_q.pop_back());
    exp_q.push_back({1'b0, 16'hE012});
    exp_q.push_back({1'b0, 16'hE013});
    enable = 1'b1;
    drive_pkt(64, 16'hE000, 0, 20, 4);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    enable  = 1'b0;
    check("rst_mid_queue", 32'(exp_q.size()), 0);
    @(negedge clock);
    check_reset_vals();
    check("rst_state", state_dbg, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    expect_pkt(16'hA000, 64, 16'hF000);
    enable = 1'b1;
    drive_pkt(64, 16'hF000, 0, 5, 1);
    drain("drain_rst");
    wait_idle("idle_rst");
    check("count_rst", packet_count, 1);

    repeat (5) @(posedge clock);
    @(negedge clock);
    check("end_quiet", bus.out_valid, 0);
    check("end_queue", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
